// File: rtl/butterfly_unit.sv
// Radix-2 DIT butterfly: A_f = A + W*B, B_f = A - W*B with rounding, saturation and a one-cycle registered output.
// Optional macro BFU_SCALE_EN applies a rounded halving to every result component before saturation.
module butterfly_unit #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [2*DW-1:0] A_t,
   input  logic [2*DW-1:0] B_t,
   input  logic [2*DW-1:0] W,
   output logic [2*DW-1:0] A_f,
   output logic [2*DW-1:0] B_f,
   output logic            out_valid,
   output logic            ovf
);

   localparam logic signed [2*DW:0]  RND     = (2*DW+1)'(1) <<< (DW-2);
   localparam logic signed [DW+1:0]  SAT_MAX = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0]  SAT_MIN = {3'b111, {(DW-1){1'b0}}};

   logic signed [DW-1:0]   ar, ai, br, bi, wr, wi;
   logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [2*DW:0]   pr_full, pi_full, pr_rnd, pi_rnd;
   logic signed [DW+1:0]   pr, pi, sr, si, dr, di;
   logic [DW:0]            sat_sr, sat_si, sat_dr, sat_di;

   logic [2*DW-1:0] a_f_q, a_f_d, b_f_q, b_f_d;
   logic            out_valid_q, out_valid_d, ovf_q, ovf_d;

   // Clamp to the DW-bit signed range; MSB of the return value flags a clamp.
   function automatic logic [DW:0] sat(input logic signed [DW+1:0] x);
      if (x > SAT_MAX) begin
         return {1'b1, 1'b0, {(DW-1){1'b1}}};
      end else if (x < SAT_MIN) begin
         return {1'b1, 1'b1, {(DW-1){1'b0}}};
      end else begin
         return {1'b0, x[DW-1:0]};
      end
   endfunction

   always_comb begin
      ar = A_t[2*DW-1:DW];
      ai = A_t[DW-1:0];
      br = B_t[2*DW-1:DW];
      bi = B_t[DW-1:0];
      wr = W[2*DW-1:DW];
      wi = W[DW-1:0];

      p_rr = wr * br;
      p_ii = wi * bi;
      p_ri = wr * bi;
      p_ir = wi * br;

      // One guard bit so (-1)(-1)+(-1)(-1) cannot wrap.
      pr_full = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
      pi_full = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);

      pr_rnd = pr_full + RND;
      pi_rnd = pi_full + RND;
      pr     = pr_rnd[2*DW:DW-1];
      pi     = pi_rnd[2*DW:DW-1];

      sr = (DW+2)'(ar) + pr;
      si = (DW+2)'(ai) + pi;
      dr = (DW+2)'(ar) - pr;
      di = (DW+2)'(ai) - pi;

`ifdef BFU_SCALE_EN
      sr = (sr + (DW+2)'(1)) >>> 1;
      si = (si + (DW+2)'(1)) >>> 1;
      dr = (dr + (DW+2)'(1)) >>> 1;
      di = (di + (DW+2)'(1)) >>> 1;
`else
`endif

      sat_sr = sat(sr);
      sat_si = sat(si);
      sat_dr = sat(dr);
      sat_di = sat(di);
   end

   always_comb begin
      a_f_d       = a_f_q;
      b_f_d       = b_f_q;
      ovf_d       = ovf_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         a_f_d = {sat_sr[DW-1:0], sat_si[DW-1:0]};
         b_f_d = {sat_dr[DW-1:0], sat_di[DW-1:0]};
         ovf_d = sat_sr[DW] | sat_si[DW] | sat_dr[DW] | sat_di[DW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_f_q       <= '0;
         b_f_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         a_f_q       <= a_f_d;
         b_f_q       <= b_f_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign A_f       = a_f_q;
   assign B_f       = b_f_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_unit.sv
// Directed self-checking bench for butterfly_unit (DW=16, BFU_SCALE_EN undefined).
// Expected values are hand-computed Q1.15 results.
module tb_butterfly_unit;

   localparam int DW = 16;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic [2*DW-1:0] A_t, B_t, W;
   logic [2*DW-1:0] A_f, B_f;
   logic            out_valid, ovf;

   int checkCount = 0;
   int errorCount = 0;

   butterfly_unit #(.DW(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .A_t      (A_t),
      .B_t      (B_t),
      .W        (W),
      .A_f      (A_f),
      .B_f      (B_f),
      .out_valid(out_valid),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Drives one set of inputs and advances past the next rising edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] w, input logic v);
      A_t      = a;
      B_t      = b;
      W        = w;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResult(input string tag, input logic [31:0] expA,
                              input logic [31:0] expB, input logic expValid, input logic expOvf);
      checkOutput({tag, ".A_f"}, A_f, expA);
      checkOutput({tag, ".B_f"}, B_f, expB);
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(expValid));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A_t      = '0;
      B_t      = '0;
      W        = '0;
      @(negedge clk);

      // Reset dominates a valid, nonzero input.
      applyStimulus(32'h7FFF_1234, 32'h7FFF_4321, 32'h7FFF_0000, 1'b1);
      applyStimulus(32'h7FFF_1234, 32'h7FFF_4321, 32'h7FFF_0000, 1'b1);
      checkResult("reset", 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
      rst_n = 1'b1;

      applyStimulus(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b1);
      checkResult("unity", 32'h6000_0000, 32'h2000_0000, 1'b1, 1'b0);

      applyStimulus(32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 1'b1);
      checkResult("minus1", 32'h2000_0000, 32'h6000_0000, 1'b1, 1'b0);

      applyStimulus(32'h4000_0000, 32'h2000_0000, 32'h0000_7FFF, 1'b1);
      checkResult("w90", 32'h4000_2000, 32'h4000_E000, 1'b1, 1'b0);

      applyStimulus(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b1);
      checkResult("satpos", 32'h7FFF_0000, 32'h0001_0000, 1'b1, 1'b1);

      // Pi = (-1)(-1)+(-1)(-1) = +2 must not wrap; clamps both ways.
      applyStimulus(32'h0000_0000, 32'h8000_8000, 32'h8000_8000, 1'b1);
      checkResult("wide", 32'h0000_7FFF, 32'h0000_8000, 1'b1, 1'b1);

      // Exact +0.5 LSB rounds up; exact -0.5 LSB rounds to zero.
      applyStimulus(32'h0000_0000, 32'h4000_0000, 32'h0001_0000, 1'b1);
      checkResult("rndpos", 32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b0);
      applyStimulus(32'h0000_0000, 32'hC000_0000, 32'h0001_0000, 1'b1);
      checkResult("rndneg", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

      // Back-to-back stream then idle with changed inputs.
      applyStimulus(32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b1);
      checkResult("stream0", 32'h3000_0000, 32'hF000_0000, 1'b1, 1'b0);
      applyStimulus(32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 1'b1);
      checkResult("stream1", 32'h2000_0000, 32'h6000_0000, 1'b1, 1'b0);
      applyStimulus(32'h4000_0000, 32'h2000_0000, 32'h0000_7FFF, 1'b1);
      checkResult("stream2", 32'h4000_2000, 32'h4000_E000, 1'b1, 1'b0);
      applyStimulus(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
      checkResult("hold0", 32'h4000_2000, 32'h4000_E000, 1'b0, 1'b0);
      applyStimulus(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
      checkResult("hold1", 32'h4000_2000, 32'h4000_E000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
